// File: rtl/alu_pkg.sv
// Shared opcode encoding and controller state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_divider.sv
// Restoring divider, one quotient bit per cycle; the first bit is resolved
// on the start edge so the quotient is ready after WIDTH edges in total.
module alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, dq_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_in, dq_in, dvs_in;
    logic [WIDTH-1:0] rem_nx, dq_nx;
    logic [WIDTH:0]   trial;

    always_comb begin
        rem_in = start ? '0 : rem_q;
        dq_in  = start ? dividend : dq_q;
        dvs_in = start ? divisor : dvs_q;
        trial  = {rem_in, dq_in[WIDTH-1]};
        dq_nx  = {dq_in[WIDTH-2:0], 1'b0};
        rem_nx = trial[WIDTH-1:0];
        if (trial >= {1'b0, dvs_in}) begin
            trial    = trial - {1'b0, dvs_in};
            rem_nx   = trial[WIDTH-1:0];
            dq_nx[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            dq_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (start) begin
            rem_q <= rem_nx;
            dq_q  <= dq_nx;
            dvs_q <= divisor;
            cnt_q <= CW'(WIDTH - 1);
            done  <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q <= rem_nx;
            dq_q  <= dq_nx;
            cnt_q <= cnt_q - 1'b1;
            done  <= (cnt_q == CW'(1));
        end else begin
            done  <= 1'b0;
        end
    end

    assign quotient = dq_q;

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: combinational op mux and flags, registered
// result, iterative divide.
//   state | meaning
//   IDLE  | no result held, ready for an operation
//   BUSY  | divider iterating, inputs ignored
//   DONE  | result/flags held until the consumer takes them
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             div_by_zero
);
    localparam int M = WIDTH - 1;

    state_t             state_q, state_nx;
    logic               accept, is_div_nz, div_done;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_c;
    logic               carry_c, ovf_c, dbz_c;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign is_div_nz = (alu_sel == OP_DIV) && (b != '0);

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        dbz_c   = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                res_c   = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
                ovf_c   = (a[M] == b[M]) && (res_c[M] != a[M]);
            end
            OP_SUB: begin
                res_c   = diff[WIDTH-1:0];
                carry_c = diff[WIDTH];
                ovf_c   = (a[M] != b[M]) && (res_c[M] != a[M]);
            end
            OP_MUL: begin
                res_c   = prod[WIDTH-1:0];
                carry_c = |prod[2*WIDTH-1:WIDTH];
            end
            // Nonzero divisors take the quotient from the divider instead.
            OP_DIV: begin
                res_c = '1;
                dbz_c = (b == '0);
            end
            OP_SHL: begin
                res_c   = {a[M-1:0], 1'b0};
                carry_c = a[M];
            end
            OP_SHR: begin
                res_c   = {1'b0, a[M:1]};
                carry_c = a[0];
            end
            OP_ROL:  res_c = {a[M-1:0], a[M]};
            OP_ROR:  res_c = {a[0], a[M:1]};
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_NOR:  res_c = ~(a | b);
            OP_NAND: res_c = ~(a & b);
            OP_XNOR: res_c = ~(a ^ b);
            OP_GT:   res_c = WIDTH'(a > b);
            OP_EQ:   res_c = WIDTH'(a == b);
            default: res_c = '0;
        endcase
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    state_nx = IDLE;
            BUSY:    if (div_done) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (accept) state_nx = is_div_nz ? BUSY : DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result      <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept && !is_div_nz) begin
            result      <= res_c;
            carry       <= carry_c;
            zero        <= (res_c == '0);
            ovf         <= ovf_c;
            div_by_zero <= dbz_c;
        end else if ((state_q == BUSY) && div_done) begin
            result      <= quotient;
            carry       <= 1'b0;
            zero        <= (quotient == '0);
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
        end
    end

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept & is_div_nz),
        .dividend (a),
        .divisor  (b),
        .done     (div_done),
        .quotient (quotient)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes model results on accept,
// monitor pops and compares whenever the ALU presents a result.
module tb_alu_mc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [3:0]   alu_sel;
    logic         carry, zero, ovf, div_by_zero;

    typedef struct {
        int unsigned res;
        bit c, z, v, d;
        int first_cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;
    bit   rr_en = 1'b0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .carry(carry), .zero(zero),
        .ovf(ovf), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference behaviour written with plain integer arithmetic.
    function automatic exp_t model(input int unsigned x, input int unsigned y,
                                   input int unsigned op);
        exp_t e;
        longint r;
        int sx, sy, s;
        int lim;
        int unsigned m;
        m   = (1 << W) - 1;
        lim = 1 << (W - 1);
        e   = '{default: 0};
        sx  = (x >= lim) ? int'(x) - (1 << W) : int'(x);
        sy  = (y >= lim) ? int'(y) - (1 << W) : int'(y);
        case (op)
            0:  begin r = x + y; e.c = (r > m); s = sx + sy; e.v = (s >= lim) || (s < -lim); end
            1:  begin r = longint'(x) - longint'(y); e.c = (x < y); s = sx - sy; e.v = (s >= lim) || (s < -lim); end
            2:  begin r = longint'(x) * longint'(y); e.c = (r > m); end
            3:  begin if (y == 0) begin r = m; e.d = 1; end else r = x / y; end
            4:  begin r = x * 2; e.c = (x >= lim); end
            5:  begin r = x / 2; e.c = (x % 2) == 1; end
            6:  r = x * 2 + x / lim;
            7:  r = x / 2 + (x % 2) * lim;
            8:  r = x & y;
            9:  r = x | y;
            10: r = x ^ y;
            11: r = ~(x | y);
            12: r = ~(x & y);
            13: r = ~(x ^ y);
            14: r = (x > y) ? 1 : 0;
            15: r = (x == y) ? 1 : 0;
            default: r = 0;
        endcase
        e.res = int'(r & longint'(m));
        e.z   = (e.res == 0);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input int unsigned x, input int unsigned y, input int unsigned op);
        exp_t e;
        int t;
        a = W'(x); b = W'(y); alu_sel = 4'(op); in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) begin
                chk("accept_timeout", t, 0);
                in_valid = 1'b0;
                return;
            end
        end
        e = model(x, y, op);
        e.first_cyc = cyc + 1 + ((op == 3 && y != 0) ? W : 0);
        sbq.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", sbq.size(), 0);
        #1;
    endtask

    // Monitor: compares the head every cycle the result is presented.
    initial begin
        bit seen;
        exp_t e;
        seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = sbq[0];
                    if (!seen) begin
                        seen = 1;
                        chk("latency", cyc, e.first_cyc);
                    end
                    chk("result", result, e.res);
                    chk("carry", carry, e.c);
                    chk("zero", zero, e.z);
                    chk("ovf", ovf, e.v);
                    chk("div_by_zero", div_by_zero, e.d);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rr_en) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int unsigned ra, rb, rop;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_sel = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry, zero, ovf, div_by_zero}, 0);
        @(posedge clk);
        #1;

        for (int op = 0; op < 16; op++) issue(40, 20, op);
        issue(8'h7F, 8'h01, 0);
        issue(8'hFF, 8'h01, 0);
        issue(5, 7, 1);
        issue(9, 0, 3);
        drain();

        issue(33, 44, 0);
        out_ready = 1'b0;
        a = 8'd1; b = 8'd2; alu_sel = 4'd0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        issue(3, 4, 9);
        issue(6, 6, 15);
        issue(250, 10, 0);
        drain();

        issue(200, 7, 3);
        repeat (W) begin
            @(negedge clk);
            chk("busy_in_ready", in_ready, 0);
        end
        drain();

        rr_en = 1'b1;
        repeat (300) begin
            ra  = $urandom_range(0, 255);
            rb  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
            rop = $urandom_range(0, 15);
            issue(ra, rb, rop);
        end
        rr_en = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        issue(100, 3, 3);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        issue(12, 5, 0);
        issue(50, 5, 3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
